// File: rtl/fifo_write_arbiter_pkg.sv
// Shared definitions for the fifo write-port arbiter: FSM state encodings and
// a pointer helper. The optional burst mode is selected with FIFO_ARB_BURST_EN.
package fifo_write_arbiter_pkg;

   typedef enum logic [0:0] {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_e;

   // Round-robin successor of idx in a ring of n requesters.
   function automatic int wrap_inc(input int idx, input int n);
      return (idx >= n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin picker: finds the first set request bit at or after
// start_i, wrapping modulo N. Returns found flag, one-hot pick and binary index.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] start_i,
   output logic          found_o,
   output logic [N-1:0]  onehot_o,
   output logic [IW-1:0] idx_o
);

   int k;

   // NOTE: every output of a combinational block gets a default before any
   // conditional assignment, otherwise the tool infers a latch.
   always_comb begin
      found_o  = 1'b0;
      onehot_o = '0;
      idx_o    = '0;
      k        = 0;
      for (int i = 0; i < N; i++) begin
         k = int'(start_i) + i;
         if (k >= N) k = k - N;
         if (!found_o && req_i[k]) begin
            found_o     = 1'b1;
            onehot_o[k] = 1'b1;
            idx_o       = IW'(k);
         end
      end
   end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one fifo write port among NUM_REQ producers.
// Define FIFO_ARB_BURST_EN to hold a grant for up to BURST_LEN beats.
module fifo_write_arbiter
   import fifo_write_arbiter_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int BURST_LEN  = 4
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
   output logic [NUM_REQ-1:0]            req_ready_o,
   output logic [NUM_REQ-1:0]            grant_o,
   output logic                          busy_o,
   output logic                          write_en_o,
   output logic [DATA_WIDTH-1:0]         write_data_o,
   input  logic                          full_i
);

   localparam int IW = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || BURST_LEN < 1) begin : g_param_check
      $error("fifo_write_arbiter: NUM_REQ must be >= 2 and BURST_LEN >= 1");
   end

   arb_state_e         state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [IW-1:0]      gidx_q, gidx_d;
   logic [IW-1:0]      rr_q, rr_d;

   logic               busy;
   logic               valid_g;
   logic               beat;
   logic               last_beat;
   logic               release_g;
   logic [IW-1:0]      rel_start;

   logic               idle_found, rel_found;
   logic [NUM_REQ-1:0] idle_onehot, rel_onehot;
   logic [IW-1:0]      idle_idx, rel_idx;

   assign busy      = (state_q == ARB_GRANT);
   assign valid_g   = |(grant_q & req_valid_i);
   assign beat      = busy & valid_g & ~full_i;
   assign rel_start = IW'(wrap_inc(int'(gidx_q), NUM_REQ));

   assign grant_o     = grant_q;
   assign busy_o      = busy;
   assign write_en_o  = beat;
   assign req_ready_o = (busy && !full_i) ? grant_q : '0;

   always_comb begin
      write_data_o = '0;
      if (beat) begin
         for (int r = 0; r < NUM_REQ; r++) begin
            if (grant_q[r]) write_data_o = write_data_o | req_data_i[r*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // IDLE pick starts at the rr pointer; release pick skips the outgoing owner.
   rr_pick #(.N(NUM_REQ), .IW(IW)) u_idle_pick (
      .req_i    (req_valid_i),
      .start_i  (rr_q),
      .found_o  (idle_found),
      .onehot_o (idle_onehot),
      .idx_o    (idle_idx)
   );

   rr_pick #(.N(NUM_REQ), .IW(IW)) u_rel_pick (
      .req_i    (req_valid_i & ~grant_q),
      .start_i  (rel_start),
      .found_o  (rel_found),
      .onehot_o (rel_onehot),
      .idx_o    (rel_idx)
   );

`ifdef FIFO_ARB_BURST_EN
   localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

   logic [BW-1:0] beat_q, beat_d;

   assign last_beat = (beat_q == BW'(BURST_LEN - 1));
`else
   assign last_beat = 1'b1;
`endif

   // A grant ends on its final beat, or as soon as the owner withdraws valid.
   assign release_g = busy & ((beat & last_beat) | ~valid_g);

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      gidx_d  = gidx_q;
      rr_d    = rr_q;
`ifdef FIFO_ARB_BURST_EN
      beat_d  = beat_q;
`endif
      unique case (state_q)
         ARB_IDLE: begin
            if (idle_found) begin
               state_d = ARB_GRANT;
               grant_d = idle_onehot;
               gidx_d  = idle_idx;
            end
         end
         ARB_GRANT: begin
            if (release_g) begin
               rr_d = rel_start;
`ifdef FIFO_ARB_BURST_EN
               beat_d = '0;
`endif
               if (rel_found) begin
                  grant_d = rel_onehot;
                  gidx_d  = rel_idx;
               end else begin
                  state_d = ARB_IDLE;
                  grant_d = '0;
                  gidx_d  = '0;
               end
            end
`ifdef FIFO_ARB_BURST_EN
            else if (beat) begin
               beat_d = beat_q + BW'(1);
            end
`endif
         end
         default: begin
            state_d = ARB_IDLE;
            grant_d = '0;
            gidx_d  = '0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q <= ARB_IDLE;
         grant_q <= '0;
         gidx_q  <= '0;
         rr_q    <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         gidx_q  <= gidx_d;
         rr_q    <= rr_d;
      end
   end

`ifdef FIFO_ARB_BURST_EN
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) beat_q <= '0;
      else          beat_q <= beat_d;
   end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter (NUM_REQ=4, DATA_WIDTH=8, BURST_LEN=4).
// The burst sequence follows FIFO_ARB_BURST_EN when it is defined.
module tb_fifo_write_arbiter;

   localparam logic [31:0] D_STD = 32'h1312_1110;
   localparam logic [31:0] D_A5  = 32'h1312_11A5;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [3:0]  req_valid = 4'h0;
   logic [31:0] req_data = D_STD;
   logic [3:0]  req_ready;
   logic [3:0]  grant;
   logic        busy;
   logic        write_en;
   logic [7:0]  write_data;
   logic        full = 1'b0;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   fifo_write_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .BURST_LEN(4)) dut (
      .clk_i        (clk),
      .reset_i      (reset_n),
      .req_valid_i  (req_valid),
      .req_data_i   (req_data),
      .req_ready_o  (req_ready),
      .grant_o      (grant),
      .busy_o       (busy),
      .write_en_o   (write_en),
      .write_data_o (write_data),
      .full_i       (full)
   );

   typedef struct {
      logic [3:0]  v;
      logic        f;
      logic [31:0] d;
      logic [3:0]  eg;
      logic        ewe;
      logic [7:0]  ed;
      logic [3:0]  er;
   } vec_t;

   vec_t tbl[19];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic check_outputs(input string tag, input logic [3:0] eg, input logic ewe,
                                input logic [7:0] ed, input logic [3:0] er);
      check({tag, ".grant"}, 32'(grant), 32'(eg));
      check({tag, ".we"},    32'(write_en), 32'(ewe));
      check({tag, ".wdata"}, 32'(write_data), 32'(ed));
      check({tag, ".ready"}, 32'(req_ready), 32'(er));
      check({tag, ".busy"},  32'(busy), 32'(|eg));
   endtask

   // Drive inputs just after a rising edge, compare on the falling edge,
   // then advance through the next rising edge.
   task automatic cyc(input string tag, input logic [3:0] v, input logic f, input logic [31:0] d,
                      input logic [3:0] eg, input logic ewe, input logic [7:0] ed, input logic [3:0] er);
      req_valid = v;
      full      = f;
      req_data  = d;
      @(negedge clk);
      check_outputs(tag, eg, ewe, ed, er);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // Post-reset table: starts in IDLE with the pointer at 0.
      tbl[0]  = '{4'hF, 1'b0, D_STD, 4'h0, 1'b0, 8'h00, 4'h0};
      tbl[1]  = '{4'h0, 1'b0, D_STD, 4'h1, 1'b0, 8'h00, 4'h1};
      tbl[2]  = '{4'h1, 1'b0, D_A5,  4'h0, 1'b0, 8'h00, 4'h0};
      tbl[3]  = '{4'h1, 1'b0, D_A5,  4'h1, 1'b1, 8'hA5, 4'h1};
      tbl[4]  = '{4'h0, 1'b0, D_STD, 4'h0, 1'b0, 8'h00, 4'h0};
      tbl[5]  = '{4'hF, 1'b0, D_STD, 4'h0, 1'b0, 8'h00, 4'h0};
      tbl[6]  = '{4'hF, 1'b0, D_STD, 4'h2, 1'b1, 8'h11, 4'h2};
      tbl[7]  = '{4'hF, 1'b0, D_STD, 4'h4, 1'b1, 8'h12, 4'h4};
      tbl[8]  = '{4'hF, 1'b0, D_STD, 4'h8, 1'b1, 8'h13, 4'h8};
      tbl[9]  = '{4'hF, 1'b0, D_STD, 4'h1, 1'b1, 8'h10, 4'h1};
      tbl[10] = '{4'hF, 1'b0, D_STD, 4'h2, 1'b1, 8'h11, 4'h2};
      for (int i = 11; i <= 15; i++) tbl[i] = '{4'hF, 1'b1, D_STD, 4'h4, 1'b0, 8'h00, 4'h0};
      tbl[16] = '{4'hF, 1'b0, D_STD, 4'h4, 1'b1, 8'h12, 4'h4};
      tbl[17] = '{4'h0, 1'b0, D_STD, 4'h8, 1'b0, 8'h00, 4'h8};
      tbl[18] = '{4'h0, 1'b0, D_STD, 4'h0, 1'b0, 8'h00, 4'h0};

      // Reset held with every requester valid: all outputs stay 0.
      req_valid = 4'hF;
      req_data  = D_STD;
      repeat (2) @(negedge clk);
      check_outputs("reset", 4'h0, 1'b0, 8'h00, 4'h0);
      #2 reset_n = 1'b1;

      // First grant one cycle after reset release goes to req0.
      cyc("first_grant", 4'hF, 1'b0, D_STD, 4'h1, 1'b1, 8'h10, 4'h1);
      cyc("full_hold",   4'hF, 1'b1, D_STD, 4'h2, 1'b0, 8'h00, 4'h0);

      // Asynchronous reset mid-grant while full: grant clears without a clock edge.
      reset_n = 1'b0;
      #1;
      check_outputs("reset_mid", 4'h0, 1'b0, 8'h00, 4'h0);
      req_valid = 4'h0;
      full      = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 19; i++) begin
         cyc($sformatf("vec%0d", i), tbl[i].v, tbl[i].f, tbl[i].d,
             tbl[i].eg, tbl[i].ewe, tbl[i].ed, tbl[i].er);
      end

      // Requesters 1 and 3 competing.
      cyc("b_idle", 4'hA, 1'b0, D_STD, 4'h0, 1'b0, 8'h00, 4'h0);
`ifdef FIFO_ARB_BURST_EN
      for (int i = 0; i < 4; i++) cyc($sformatf("b_r1_%0d", i), 4'hA, 1'b0, D_STD, 4'h2, 1'b1, 8'h11, 4'h2);
      for (int i = 0; i < 4; i++) cyc($sformatf("b_r3_%0d", i), 4'hA, 1'b0, D_STD, 4'h8, 1'b1, 8'h13, 4'h8);
      for (int i = 0; i < 2; i++) cyc($sformatf("b_r1b_%0d", i), 4'hA, 1'b0, D_STD, 4'h2, 1'b1, 8'h11, 4'h2);
      cyc("b_r1_drop", 4'h8, 1'b0, D_STD, 4'h2, 1'b0, 8'h00, 4'h2);
      cyc("b_r3_sw",   4'h8, 1'b0, D_STD, 4'h8, 1'b1, 8'h13, 4'h8);
      cyc("b_r3_drop", 4'h0, 1'b0, D_STD, 4'h8, 1'b0, 8'h00, 4'h8);
`else
      for (int i = 0; i < 2; i++) begin
         cyc($sformatf("rr_r1_%0d", i), 4'hA, 1'b0, D_STD, 4'h2, 1'b1, 8'h11, 4'h2);
         cyc($sformatf("rr_r3_%0d", i), 4'hA, 1'b0, D_STD, 4'h8, 1'b1, 8'h13, 4'h8);
      end
      cyc("rr_r1_drop", 4'h0, 1'b0, D_STD, 4'h2, 1'b0, 8'h00, 4'h2);
`endif
      cyc("b_end", 4'h0, 1'b0, D_STD, 4'h0, 1'b0, 8'h00, 4'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
